// File: rtl/sar_pkg.sv
// Shared types and helpers for the SAR result filter.
// Output FSM state, accumulator width helper, round-half-up shift.
package sar_pkg;

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } out_state_t;

   function automatic int acc_width(input int w, input int l);
      return w + l;
   endfunction

   function automatic logic [31:0] round_shr(input logic [31:0] sum,
                                             input int          sh);
      logic [31:0] half;
      half = (sh == 0) ? 32'd0 : (32'd1 << (sh - 1));
      return (sum + half) >> sh;
   endfunction

endpackage

// File: rtl/sar_accum.sv
// Boxcar accumulator: window counter, sum and completion pulse.
// Running min/max trackers exist only with SAR_FILT_MINMAX_EN.
module sar_accum
   import sar_pkg::*;
#(
   parameter  int WIDTH    = 8,
   parameter  int AVG_LOG2 = 2,
   localparam int CW       = (AVG_LOG2 < 1) ? 1 : AVG_LOG2,
   localparam int AW       = acc_width(WIDTH, AVG_LOG2)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_code,
   input  logic             i_valid,
   input  logic             i_restart,
   output logic [CW-1:0]    o_fill,
   output logic             o_done,
   output logic [WIDTH-1:0] o_result
`ifdef SAR_FILT_MINMAX_EN
   ,
   output logic [WIDTH-1:0] o_min,
   output logic [WIDTH-1:0] o_max
`endif
);

   localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);

   logic [AW-1:0] r_acc;
   logic [CW-1:0] r_cnt;
   logic          w_take;
   logic          w_last;
   logic [AW-1:0] w_sum;

   assign w_take   = i_valid && !i_restart;
   assign w_last   = (r_cnt == LAST);
   assign o_done   = w_take && w_last;
   assign w_sum    = r_acc + AW'(i_code);
   assign o_result = WIDTH'(round_shr(32'(w_sum), AVG_LOG2));
   assign o_fill   = r_cnt;

   // Accumulate codes; clear on window completion or restart
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (i_restart || o_done) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (w_take) begin
         r_acc <= w_sum;
         r_cnt <= r_cnt + CW'(1);
      end
   end

`ifdef SAR_FILT_MINMAX_EN
   logic [WIDTH-1:0] r_min;
   logic [WIDTH-1:0] r_max;

   assign o_min = (i_code < r_min) ? i_code : r_min;
   assign o_max = (i_code > r_max) ? i_code : r_max;

   // Track window extremes; re-arm at window boundaries
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_min <= '1;
         r_max <= '0;
      end else if (i_restart || o_done) begin
         r_min <= '1;
         r_max <= '0;
      end else if (w_take) begin
         r_min <= o_min;
         r_max <= o_max;
      end
   end
`endif

endmodule

// File: rtl/sar_result_filter.sv
// SAR result filter: averaging plus held result with valid/ready.
// Optional min/max outputs under SAR_FILT_MINMAX_EN.
module sar_result_filter
   import sar_pkg::*;
#(
   parameter  int WIDTH    = 8,
   parameter  int AVG_LOG2 = 2,
   localparam int CW       = (AVG_LOG2 < 1) ? 1 : AVG_LOG2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] code_in,
   input  logic             code_valid,
   input  logic             restart,
   output logic [WIDTH-1:0] avg_out,
   output logic             avg_valid,
   input  logic             avg_ready,
   output logic             overrun,
   input  logic             clear_overrun,
   output logic [CW-1:0]    fill_cnt
`ifdef SAR_FILT_MINMAX_EN
   ,
   output logic [WIDTH-1:0] min_out,
   output logic [WIDTH-1:0] max_out
`endif
);

   out_state_t       r_state;
   out_state_t       w_next;
   logic             w_done;
   logic [WIDTH-1:0] w_result;
   logic [WIDTH-1:0] r_avg;
   logic             r_ovr;

`ifdef SAR_FILT_MINMAX_EN
   logic [WIDTH-1:0] w_min;
   logic [WIDTH-1:0] w_max;
   logic [WIDTH-1:0] r_min;
   logic [WIDTH-1:0] r_max;
`endif

   sar_accum #(
      .WIDTH    (WIDTH),
      .AVG_LOG2 (AVG_LOG2)
   ) u_accum (
      .clk       (clk),
      .reset     (reset),
      .i_code    (code_in),
      .i_valid   (code_valid),
      .i_restart (restart),
      .o_fill    (fill_cnt),
      .o_done    (w_done),
      .o_result  (w_result)
`ifdef SAR_FILT_MINMAX_EN
      ,
      .o_min     (w_min),
      .o_max     (w_max)
`endif
   );

   // Output state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_EMPTY;
      else       r_state <= w_next;
   end

   // Next state: a completion always leaves a result held
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_EMPTY: if (w_done) w_next = S_FULL;
         S_FULL:  if (!w_done && avg_ready) w_next = S_EMPTY;
         default: w_next = S_EMPTY;
      endcase
   end

   // Valid is a pure decode of the registered state
   always_comb begin
      avg_valid = (r_state == S_FULL);
   end

   // Holding register loads on every completion
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_avg <= '0;
      end else if (w_done) begin
         r_avg <= w_result;
      end
   end

   // Sticky overrun: set wins over clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ovr <= 1'b0;
      end else if (r_state == S_FULL && w_done && !avg_ready) begin
         r_ovr <= 1'b1;
      end else if (clear_overrun) begin
         r_ovr <= 1'b0;
      end
   end

   assign avg_out = r_avg;
   assign overrun = r_ovr;

`ifdef SAR_FILT_MINMAX_EN
   // Extremes load together with the average
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_min <= '0;
         r_max <= '0;
      end else if (w_done) begin
         r_min <= w_min;
         r_max <= w_max;
      end
   end

   assign min_out = r_min;
   assign max_out = r_max;
`endif

endmodule

// File: doc/sar_result_filter.md
# sar_result_filter

Downstream consumer of the SAR conversion core. Captures each finished conversion code on the core's one-cycle `ready` pulse, boxcar-averages blocks of 2^AVG_LOG2 codes with round-half-up, and presents each averaged result in a holding register with a valid/ready handshake to the readout logic (display, UART, or host register). Tracks output overrun when the consumer falls behind.

## Interface
- WIDTH, 8: conversion code width; must equal the SAR core WIDTH.
- AVG_LOG2, 2: log2 of the averaging window N (0..8); 0 is passthrough.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- code_in  input  WIDTH  SAR trial_code; sampled only when code_valid=1.
- code_valid  input  1  SAR `ready` pulse; one code per high cycle.
- restart  input  1  synchronous; discards the partial window.
- avg_out  output  WIDTH  averaged result; stable while avg_valid=1.
- avg_valid  output  1  result available.
- avg_ready  input  1  consumer accepts; transfer when avg_valid && avg_ready.
- overrun  output  1  sticky; a held result was overwritten.
- clear_overrun  input  1  synchronous clear of overrun.
- fill_cnt  output  AVG_LOG2 (min 1)  codes accumulated in the current window.

## Operation
- Accumulator `acc` is WIDTH+AVG_LOG2 bits. Window counter `fill_cnt` runs 0..N-1.
- On code_valid with fill_cnt<N-1: acc += code_in; fill_cnt++.
- On code_valid with fill_cnt==N-1 (window complete): result = (acc + code_in + N/2) >> AVG_LOG2. The N/2 term is 0 when AVG_LOG2=0. The result provably fits WIDTH bits; no saturation logic. Then acc<=0 and fill_cnt<=0.
- restart: acc<=0 and fill_cnt<=0, and any code_valid in the same cycle is discarded. restart does not touch the output register or overrun.
- Output FSM, two states:
  - S_EMPTY (avg_valid=0): a completed window loads avg_out and moves to S_FULL.
  - S_FULL (avg_valid=1), by case:
    - Handshake without a completion: go to S_EMPTY.
    - Completion without a handshake: overwrite avg_out, set overrun, stay in S_FULL.
    - Completion and handshake in the same cycle: the old value is transferred, the new one loads, overrun stays unchanged, stay in S_FULL.
- overrun: set as above. clear_overrun clears it. If a set and a clear coincide, the set wins.
- avg_ready is ignored in S_EMPTY.

## Timing
- Reset values: avg_out=0, avg_valid=0, overrun=0, fill_cnt=0, acc=0, state S_EMPTY.
- Latency: avg_valid rises on the clock edge that samples the window's final code_valid, so it is visible the following cycle.
- Throughput: one code per cycle is accepted. Back-to-back code_valid is legal even though the SAR core never produces it.
- Reset asserted mid-window or mid-hold takes effect immediately and asynchronously. The first code after reset deassertion begins a fresh window.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- SAR_FILT_MINMAX_EN defined:
  - Adds outputs min_out and max_out (WIDTH each). These hold the minimum and maximum raw code of the window most recently loaded into avg_out, and they load atomically with avg_out.
  - Reset value: min_out=0, max_out=0.
  - restart also resets the running min/max trackers, to all-ones and zero respectively.
- Undefined: the ports and trackers are absent. All other behaviour is identical.

## Structure
- Shared package `sar_pkg`:
  - out_state_t enum {S_EMPTY, S_FULL}.
  - localparam helper for the accumulator width (WIDTH+AVG_LOG2).
  - The round-half-up function.
- One sub-module, `sar_accum`: accumulator plus window counter plus completion pulse (and the min/max trackers when the macro is set). The top holds the output FSM and the overrun logic.

## Test plan
- WIDTH=8, AVG_LOG2=2: codes 10,11,12,13 -> sum 46 +2 = 48 >> 2 -> avg_out=12, avg_valid=1 one cycle after the 4th code; with SAR_FILT_MINMAX_EN, min_out=10 and max_out=13.
- AVG_LOG2=0: codes 0x00, 0xFF, 0x7F, each accepted immediately -> avg_out equals each code, latency 1 cycle.
- Four codes of 255 -> (1020+2)>>2 = 255, no wrap; four codes of 1,1,1,2 -> (5+2)>>2 = 1.
- avg_ready held 0 across two complete windows (12 then 20) -> avg_out=20, overrun=1. clear_overrun -> overrun=0. Repeat with clear_overrun pulsed in the same cycle as a new overrun -> overrun stays 1.
- Window completion coincides with the handshake of the prior result -> consumer sees old value, avg_out takes new value, avg_valid stays 1, overrun=0.
- Reset pulsed after 2 of 4 codes, then 4 codes of 40 -> avg_out=40. restart after 3 codes, then 4 codes of 8 -> avg_out=8.
